// File: rtl/bpe_stage_ctrl.sv
// bpe_stage_ctrl: LOAD/CALC sequencer for one butterfly stage of the SDF FFT/NTT kernel.
// Build option BPE_BITREV_LOAD_EN: stream-in words are written at bit-reversed buffer addresses.

module bpe_stage_ctrl #(
    parameter int pADDR_WIDTH = 10,
    parameter int pSPAN       = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic                   buf_we,
    output logic [pADDR_WIDTH-1:0] buf_waddr,
    output logic                   rd_vld,
    input  logic                   rd_rdy,
    output logic [pADDR_WIDTH-1:0] rd_addr_a,
    output logic [pADDR_WIDTH-1:0] rd_addr_b,
    output logic [pADDR_WIDTH-2:0] cst_addr,
    output logic [1:0]             cst_sel,
    output logic                   busy,
    output logic                   done
);

    localparam logic [pADDR_WIDTH-1:0] LP_ONE   = {{(pADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pADDR_WIDTH-2:0] LP_JONE  = {{(pADDR_WIDTH-2){1'b0}}, 1'b1};
    localparam logic [pADDR_WIDTH-1:0] LP_D     = LP_ONE << pSPAN;
    localparam logic [pADDR_WIDTH-1:0] LP_MASK  = LP_D - LP_ONE;
    localparam logic [pADDR_WIDTH-2:0] LP_CMASK = LP_MASK[pADDR_WIDTH-2:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [pADDR_WIDTH-1:0]   r_wcnt;
    logic [pADDR_WIDTH-2:0]   r_j;
    logic                     r_rd_vld;
    logic [pADDR_WIDTH-1:0]   r_addr_a;
    logic [pADDR_WIDTH-1:0]   r_addr_b;
    logic [pADDR_WIDTH-2:0]   r_cst;
    logic [1:0]               r_cst_sel;

    logic                     w_wr;
    logic                     w_hs;
    logic                     w_load_last;
    logic                     w_calc_last;
    logic [pADDR_WIDTH-2:0]   w_j_nxt;
    logic [pADDR_WIDTH-1:0]   w_jx;
    logic [pADDR_WIDTH-1:0]   w_a_nxt;
    logic [pADDR_WIDTH-1:0]   w_b_nxt;
    logic [pADDR_WIDTH-2:0]   w_cst_nxt;

    assign w_wr        = in_vld & (r_state == ST_LOAD);
    assign w_hs        = r_rd_vld & rd_rdy;
    assign w_load_last = w_wr & (r_wcnt == '1);
    assign w_calc_last = w_hs & (r_j == '1);

    // Addresses are precomputed for j+1 so the registered outputs advance on each handshake.
    assign w_j_nxt   = r_j + LP_JONE;
    assign w_jx      = {1'b0, w_j_nxt};
    assign w_a_nxt   = ((w_jx >> pSPAN) << (pSPAN + 1)) | (w_jx & LP_MASK);
    assign w_b_nxt   = w_a_nxt | LP_D;
    assign w_cst_nxt = (w_j_nxt & LP_CMASK) << (pADDR_WIDTH - 1 - pSPAN);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)       w_state_nxt = ST_LOAD;
            ST_LOAD: if (w_load_last) w_state_nxt = ST_CALC;
            ST_CALC: if (w_calc_last) w_state_nxt = ST_DONE;
            ST_DONE:                  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt    <= '0;
            r_j       <= '0;
            r_rd_vld  <= 1'b0;
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_cst     <= '0;
            r_cst_sel <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) r_cst_sel <= mode;
            if (w_wr) r_wcnt <= r_wcnt + LP_ONE;
            if (w_load_last) begin
                r_rd_vld <= 1'b1;
                r_addr_a <= '0;
                r_addr_b <= LP_D;
                r_cst    <= '0;
            end
            // j wraps to 0 on the final handshake, leaving the counter ready for the next run.
            if (w_hs) begin
                r_j <= w_j_nxt;
                if (w_calc_last) begin
                    r_rd_vld <= 1'b0;
                    r_addr_a <= '0;
                    r_addr_b <= '0;
                    r_cst    <= '0;
                end else begin
                    r_addr_a <= w_a_nxt;
                    r_addr_b <= w_b_nxt;
                    r_cst    <= w_cst_nxt;
                end
            end
        end
    end

`ifdef BPE_BITREV_LOAD_EN
    assign buf_waddr = {<<{r_wcnt}};
`else
    assign buf_waddr = r_wcnt;
`endif

    assign in_rdy    = (r_state == ST_LOAD);
    assign buf_we    = w_wr;
    assign rd_vld    = r_rd_vld;
    assign rd_addr_a = r_addr_a;
    assign rd_addr_b = r_addr_b;
    assign cst_addr  = r_cst;
    assign cst_sel   = r_cst_sel;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule
